// File: rtl/net_resolver.sv
// net_resolver: wire/wand/wor resolution of several enabled drivers onto one registered net
module net_resolver #(
    parameter int NUM_DRV    = 4,
    parameter int WIDTH      = 4,
    parameter int CNT_W      = 8,
    parameter int ERR_THRESH = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               mode,
    input  logic                     in_valid,
    input  logic [NUM_DRV-1:0]       drv_en,
    input  logic [NUM_DRV*WIDTH-1:0] drv_data,
    input  logic                     clr,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         net_val,
    output logic [WIDTH-1:0]         z_mask,
    output logic [WIDTH-1:0]         x_mask,
    output logic [CNT_W-1:0]         cont_cnt,
    output logic                     err_sticky,
    output logic                     err_irq
);
    localparam logic [CNT_W-1:0] THRESH = CNT_W'(ERR_THRESH);

    logic [WIDTH-1:0] and_v, or_v, z_c, x_c, val_c;
    logic [CNT_W-1:0] cnt_next;
    logic             wire_mode, event_c;

    assign wire_mode = (mode != 2'd1) && (mode != 2'd2);
    assign event_c   = in_valid && (|x_c);

    // Disabled drivers are forced to the identity of each reduction so their data never leaks in
    always_comb begin
        and_v = '1;
        or_v  = '0;
        for (int i = 0; i < NUM_DRV; i++) begin
            and_v &= drv_data[i*WIDTH +: WIDTH] | {WIDTH{~drv_en[i]}};
            or_v  |= drv_data[i*WIDTH +: WIDTH] & {WIDTH{drv_en[i]}};
        end
        z_c   = {WIDTH{~|drv_en}};
        x_c   = wire_mode ? ((and_v ^ or_v) & ~z_c) : '0;
        val_c = (mode == 2'd2 ? or_v : and_v) & ~z_c & ~x_c;
    end

    // Next contention count: clr wins, otherwise saturating increment per event cycle
    always_comb begin
        cnt_next = cont_cnt;
        if (clr)
            cnt_next = '0;
        else if (event_c && cont_cnt != '1)
            cnt_next = cont_cnt + 1'b1;
    end

    // Data path registers, updated only on valid cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            net_val   <= '0;
            z_mask    <= '1;
            x_mask    <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                net_val <= val_c;
                z_mask  <= z_c;
                x_mask  <= x_c;
            end
        end
    end

    // Contention counter, sticky flag and threshold interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cont_cnt   <= '0;
            err_sticky <= 1'b0;
            err_irq    <= 1'b0;
        end else begin
            cont_cnt   <= cnt_next;
            err_sticky <= !clr && (err_sticky || event_c);
            err_irq    <= cnt_next >= THRESH;
        end
    end
endmodule

// File: tb/tb_net_resolver.sv
// tb_net_resolver: table-driven, sequence and randomized checks of net_resolver against a reference model
module tb_net_resolver;
    localparam int N = 4;
    localparam int W = 4;

    logic           clk, rst_n, in_valid, clr;
    logic [1:0]     mode;
    logic [N-1:0]   drv_en;
    logic [N*W-1:0] drv_data;
    logic           out_valid, err_sticky, err_irq;
    logic [W-1:0]   net_val, z_mask, x_mask;
    logic [7:0]     cont_cnt;
    logic           ov2, sticky2, irq2;
    logic [W-1:0]   val2, z2, x2;
    logic [1:0]     cnt2;

    net_resolver #(.NUM_DRV(N), .WIDTH(W), .CNT_W(8), .ERR_THRESH(3)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .drv_en(drv_en),
        .drv_data(drv_data), .clr(clr), .out_valid(out_valid), .net_val(net_val),
        .z_mask(z_mask), .x_mask(x_mask), .cont_cnt(cont_cnt), .err_sticky(err_sticky),
        .err_irq(err_irq)
    );

    net_resolver #(.NUM_DRV(N), .WIDTH(W), .CNT_W(2), .ERR_THRESH(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .drv_en(drv_en),
        .drv_data(drv_data), .clr(clr), .out_valid(ov2), .net_val(val2),
        .z_mask(z2), .x_mask(x2), .cont_cnt(cnt2), .err_sticky(sticky2),
        .err_irq(irq2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic         m_ov, m_sticky, m_irq, m_sticky2, m_irq2;
    logic [W-1:0] m_val, m_z, m_x;
    int           m_cnt, m_cnt2;

    typedef struct {
        logic [1:0]     mode;
        logic [N-1:0]   en;
        logic [N*W-1:0] data;
        logic [W-1:0]   val;
        logic [W-1:0]   z;
        logic [W-1:0]   x;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ov = 0; m_val = 0; m_z = '1; m_x = 0;
        m_cnt = 0; m_sticky = 0; m_irq = 0;
        m_cnt2 = 0; m_sticky2 = 0; m_irq2 = 0;
    endtask

    // Resolves each bit by counting enabled ones and zeros, then advances the counters
    task automatic model_step();
        logic [W-1:0] v, z, x;
        v = 0; z = 0; x = 0;
        for (int b = 0; b < W; b++) begin
            int n0, n1;
            n0 = 0; n1 = 0;
            for (int d = 0; d < N; d++)
                if (drv_en[d]) begin
                    if (drv_data[d*W+b] === 1'b1) n1++;
                    else n0++;
                end
            if (n0 + n1 == 0) z[b] = 1;
            else if (mode == 1) v[b] = (n0 == 0);
            else if (mode == 2) v[b] = (n1 > 0);
            else if (n0 > 0 && n1 > 0) x[b] = 1;
            else v[b] = (n1 > 0);
        end
        m_ov = in_valid;
        if (in_valid) begin
            m_val = v; m_z = z; m_x = x;
        end
        if (clr) begin
            m_cnt = 0; m_sticky = 0; m_cnt2 = 0; m_sticky2 = 0;
        end else if (in_valid && x != 0) begin
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
            m_sticky = 1; m_sticky2 = 1;
        end
        m_irq = m_cnt >= 3;
        m_irq2 = m_cnt2 >= 3;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
        chk({tag, ".net_val"}, 32'(net_val), 32'(m_val));
        chk({tag, ".z_mask"}, 32'(z_mask), 32'(m_z));
        chk({tag, ".x_mask"}, 32'(x_mask), 32'(m_x));
        chk({tag, ".cont_cnt"}, 32'(cont_cnt), 32'(m_cnt));
        chk({tag, ".err_sticky"}, 32'(err_sticky), 32'(m_sticky));
        chk({tag, ".err_irq"}, 32'(err_irq), 32'(m_irq));
        chk({tag, ".cnt_w2"}, 32'(cnt2), 32'(m_cnt2));
        chk({tag, ".sticky_w2"}, 32'(sticky2), 32'(m_sticky2));
        chk({tag, ".irq_w2"}, 32'(irq2), 32'(m_irq2));
    endtask

    task automatic step(input string tag, input logic [1:0] md, input logic iv,
                        input logic [N-1:0] en, input logic [N*W-1:0] data, input logic c);
        mode = md; in_valid = iv; drv_en = en; drv_data = data; clr = c;
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        // d0 in [3:0], d1 in [7:4]
        tbl[0] = '{2'd0, 4'b0000, 16'h1234, 4'h0, 4'hF, 4'h0};
        tbl[1] = '{2'd0, 4'b0001, 16'h5F3A, 4'hA, 4'h0, 4'h0};
        tbl[2] = '{2'd0, 4'b0011, 16'h00AA, 4'hA, 4'h0, 4'h0};
        tbl[3] = '{2'd0, 4'b0011, 16'h006A, 4'h2, 4'h0, 4'hC};
        tbl[4] = '{2'd1, 4'b0011, 16'h00AC, 4'h8, 4'h0, 4'h0};
        tbl[5] = '{2'd2, 4'b0011, 16'h00AC, 4'hE, 4'h0, 4'h0};
        tbl[6] = '{2'd3, 4'b0011, 16'h006A, 4'h2, 4'h0, 4'hC};
        tbl[7] = '{2'd2, 4'b0000, 16'hFFFF, 4'h0, 4'hF, 4'h0};

        rst_n = 0; in_valid = 0; clr = 0; mode = 0; drv_en = 0; drv_data = 0;
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1;

        for (int i = 0; i < 8; i++) begin
            step($sformatf("tbl%0d", i), tbl[i].mode, 1'b1, tbl[i].en, tbl[i].data, 1'b0);
            chk($sformatf("tbl%0d.val", i), 32'(net_val), 32'(tbl[i].val));
            chk($sformatf("tbl%0d.z", i), 32'(z_mask), 32'(tbl[i].z));
            chk($sformatf("tbl%0d.x", i), 32'(x_mask), 32'(tbl[i].x));
        end
        chk("tbl.cnt_after_two_events", 32'(cont_cnt), 32'd2);

        // Asynchronous reset mid-stream, checked before the next edge
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check_all("async_reset");
        #1;
        rst_n = 1;

        // Threshold and saturation
        for (int i = 0; i < 5; i++)
            step($sformatf("thr%0d", i), 2'd0, 1'b1, 4'b0011, 16'h006A, 1'b0);
        chk("thr.cnt8", 32'(cont_cnt), 32'd5);
        chk("thr.cnt2_sat", 32'(cnt2), 32'd3);
        chk("thr.irq", 32'(err_irq), 32'd1);
        step("clr_event", 2'd0, 1'b1, 4'b0011, 16'h006A, 1'b1);
        chk("clr.cnt", 32'(cont_cnt), 32'd0);
        chk("clr.sticky", 32'(err_sticky), 32'd0);
        chk("clr.irq", 32'(err_irq), 32'd0);

        // Pipeline gap: data holds while in_valid is low
        step("gap_a", 2'd0, 1'b1, 4'b0001, 16'h0005, 1'b0);
        step("gap_b", 2'd0, 1'b0, 4'b0001, 16'h0009, 1'b0);
        chk("gap.hold", 32'(net_val), 32'h5);
        chk("gap.ov_low", 32'(out_valid), 32'd0);
        step("gap_c", 2'd2, 1'b1, 4'b0101, 16'h0300, 1'b0);
        chk("gap.new", 32'(net_val), 32'h3);
        step("xdata", 2'd0, 1'b1, 4'b0001, {12'hxxx, 4'b1010}, 1'b0);
        chk("xdata.val", 32'(net_val), 32'hA);

        // Randomized stimulus
        for (int i = 0; i < 400; i++)
            step("rand", 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                 4'($urandom), 16'($urandom), ($urandom_range(0, 15) == 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
